// File: rtl/simplez_fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | simplez_fetch_pkg : shared widths, opcodes and fetch FSM states  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package simplez_fetch_pkg;

   localparam int c_aw_default  = 9;
   localparam int c_dw_default  = 12;
   localparam int c_opw_default = 3;

   typedef enum logic [2:0] {
      OP_ST   = 3'd0,
      OP_LD   = 3'd1,
      OP_ADD  = 3'd2,
      OP_BR   = 3'd3,
      OP_BZ   = 3'd4,
      OP_CLR  = 3'd5,
      OP_DEC  = 3'd6,
      OP_HALT = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_VALID = 3'd2,
      S_DREAD = 3'd3,
      S_HALT  = 3'd4
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/simplez_pc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | simplez_pc : program counter with increment and branch load      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module simplez_pc #(
   parameter int AW       = 9,
   parameter int RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          inc,
   input  logic          load,
   input  logic [AW-1:0] load_addr,
   output logic [AW-1:0] pc
);

   logic [AW-1:0] r_pc;

   // Wrap from 2**AW-1 to 0 falls out of the fixed-width add.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_pc <= AW'(RESET_PC);
      else if (load)
         r_pc <= load_addr;
      else if (inc)
         r_pc <= r_pc + AW'(1);
   end

   assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/simplez_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | simplez_fetch : Simplez fetch sequencer and memory-port mux      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module simplez_fetch
   import simplez_fetch_pkg::*;
#(
   parameter int AW       = c_aw_default,
   parameter int DW       = c_dw_default,
   parameter int OPW      = c_opw_default,
   parameter int RESET_PC = 0
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           start,
   output logic [AW-1:0]  mem_addr,
   output logic           mem_re,
   input  logic [DW-1:0]  mem_rdata,
   output logic           instr_valid,
   input  logic           instr_ready,
   output logic [OPW-1:0] opcode,
   output logic [AW-1:0]  cd,
   output logic [AW-1:0]  pc,
   input  logic           br_valid,
   input  logic [AW-1:0]  br_addr,
   input  logic           dreq,
   input  logic [AW-1:0]  daddr,
   output logic           dvalid,
   output logic [DW-1:0]  drdata,
   output logic           halted
);

   fetch_state_e  r_state, w_state_nxt;
   logic [DW-1:0] r_ir;
   logic [AW-1:0] r_daddr_q;
   logic [DW-1:0] r_drdata;
   logic          r_dvalid;
   logic          w_is_halt;
   logic          w_accept;
   logic          w_pc_inc;
   logic          w_pc_load;
   logic          w_dread_go;

   assign opcode    = r_ir[DW-1 -: OPW];
   assign cd        = r_ir[AW-1:0];
   assign w_is_halt = (opcode == OPW'(OP_HALT));
   assign w_accept  = (r_state == S_VALID) && instr_ready;
   assign w_pc_inc  = (r_state == S_FETCH);
   // A retiring HALT must not redirect the PC even if a branch is flagged.
   assign w_pc_load  = w_accept && br_valid && !w_is_halt;
   assign w_dread_go = (r_state == S_VALID) && !instr_ready && dreq;

   simplez_pc #(
      .AW       (AW),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk       (clk),
      .rstn      (rstn),
      .inc       (w_pc_inc),
      .load      (w_pc_load),
      .load_addr (br_addr),
      .pc        (pc)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_addr    = '0;
      mem_re      = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_addr    = pc;
            mem_re      = 1'b1;
            w_state_nxt = S_VALID;
         end
         S_VALID: begin
            instr_valid = 1'b1;
            if (instr_ready)
               w_state_nxt = w_is_halt ? S_HALT : S_FETCH;
            else if (dreq)
               w_state_nxt = S_DREAD;
         end
         S_DREAD: begin
            mem_addr    = r_daddr_q;
            mem_re      = 1'b1;
            w_state_nxt = S_VALID;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Memory output is registered on the negedge, so it is settled by this posedge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ir      <= '0;
         r_daddr_q <= '0;
         r_drdata  <= '0;
         r_dvalid  <= 1'b0;
      end else begin
         if (r_state == S_FETCH)
            r_ir <= mem_rdata;
         if (w_dread_go)
            r_daddr_q <= daddr;
         if (r_state == S_DREAD)
            r_drdata <= mem_rdata;
         r_dvalid <= (r_state == S_DREAD);
      end
   end

   assign dvalid = r_dvalid;
   assign drdata = r_drdata;

   a_no_dreq_with_ready : assert property (
      @(posedge clk) disable iff (!rstn)
      !((r_state == S_VALID) && instr_ready && dreq)
   );

endmodule
`default_nettype wire

// File: tb/tb_simplez_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_simplez_fetch : directed bench with reference model + memory  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_simplez_fetch;

   localparam int AW = 9;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start, instr_ready, br_valid, dreq;
   logic [AW-1:0] br_addr, daddr;
   logic [AW-1:0] mem_addr, cd, pc;
   logic          mem_re, instr_valid, dvalid, halted;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] drdata;
   logic [2:0]    opcode;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_fail   = 0;

   simplez_fetch dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .mem_addr    (mem_addr),
      .mem_re      (mem_re),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .cd          (cd),
      .pc          (pc),
      .br_valid    (br_valid),
      .br_addr     (br_addr),
      .dreq        (dreq),
      .daddr       (daddr),
      .dvalid      (dvalid),
      .drdata      (drdata),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // Memory with negedge-registered read port.
   always @(negedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 request, 2 presented, 3 data read, 4 stopped.
   int            m_phase;
   logic [AW-1:0] m_pc, m_daddr;
   logic [DW-1:0] m_ir, m_drdata;
   logic          m_dvalid;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_phase <= 0; m_pc <= '0; m_ir <= '0; m_drdata <= '0; m_dvalid <= 1'b0; m_daddr <= '0;
      end else begin
         m_dvalid <= (m_phase == 3);
         case (m_phase)
            0: if (start) m_phase <= 1;
            1: begin m_ir <= mem[m_pc]; m_pc <= AW'((int'(m_pc) + 1) % (1 << AW)); m_phase <= 2; end
            2: if (instr_ready) begin
                  if (m_ir[DW-1 -: 3] == 3'd7) m_phase <= 4;
                  else begin
                     if (br_valid) m_pc <= br_addr;
                     m_phase <= 1;
                  end
               end else if (dreq) begin
                  m_daddr <= daddr; m_phase <= 3;
               end
            3: begin m_drdata <= mem[m_daddr]; m_phase <= 2; end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("m_instr_valid", instr_valid, m_phase == 2);
      chk("m_mem_re", mem_re, (m_phase == 1) || (m_phase == 3));
      if (m_phase == 1) chk("m_fetch_addr", mem_addr, m_pc);
      if (m_phase == 3) chk("m_dread_addr", mem_addr, m_daddr);
      if (m_phase == 2) begin
         chk("m_opcode", opcode, m_ir[DW-1 -: 3]);
         chk("m_cd", cd, m_ir[AW-1:0]);
      end
      chk("m_pc", pc, m_pc);
      chk("m_halted", halted, m_phase == 4);
      chk("m_dvalid", dvalid, m_dvalid);
      chk("m_drdata", drdata, m_drdata);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[0]     = 12'o0400;
      mem[1]     = 12'o7000;
      mem[5]     = 12'o3020;
      mem[9'h1FF] = 12'hABC;
      mem[9'h003] = 12'h123;

      rstn = 1'b0; start = 0; instr_ready = 0; br_valid = 0; dreq = 0; br_addr = '0; daddr = '0;
      cyc(); cyc();
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_halted", halted, 0);
      chk("rst_pc", pc, 0);
      rstn = 1'b1;
      cyc();
      start = 1;
      cyc();                                  // FETCH of address 0
      chk("f0_addr", mem_addr, 0);
      chk("f0_re", mem_re, 1);
      start = 0;
      cyc();                                  // VALID
      chk("f0_valid", instr_valid, 1);
      chk("f0_opcode", opcode, 0);
      chk("f0_cd", cd, 9'h100);
      chk("f0_pc", pc, 1);
      dreq = 1; daddr = 9'h1FF;
      cyc();                                  // DREAD
      chk("dr_re", mem_re, 1);
      chk("dr_addr", mem_addr, 9'h1FF);
      chk("dr_valid_low", instr_valid, 0);
      dreq = 0;
      cyc();                                  // back in VALID
      chk("dr_dvalid", dvalid, 1);
      chk("dr_data", drdata, 12'hABC);
      chk("dr_valid_back", instr_valid, 1);
      chk("dr_cd_kept", cd, 9'h100);
      cyc();
      chk("dr_dvalid_pulse", dvalid, 0);
      chk("dr_data_held", drdata, 12'hABC);
      dreq = 1; daddr = 9'h003;
      cyc();                                  // DREAD, then reset mid-state
      dreq = 0;
      rstn = 1'b0;
      #1;
      chk("rm_re", mem_re, 0);
      chk("rm_valid", instr_valid, 0);
      chk("rm_pc", pc, 0);
      chk("rm_dvalid", dvalid, 0);
      chk("rm_drdata", drdata, 0);
      cyc();
      rstn = 1'b1;
      start = 1;
      cyc();                                  // FETCH 0
      start = 0; instr_ready = 1; br_valid = 1; br_addr = 9'd5;
      cyc();                                  // VALID (ST), accepted with branch to 5
      cyc();
      chk("br5_addr", mem_addr, 9'd5);
      br_addr = 9'o020;
      cyc();                                  // VALID: BR 20o
      chk("br_opcode", opcode, 3'd3);
      chk("br_cd", cd, 9'o020);
      cyc();
      chk("br20_addr", mem_addr, 9'h010);
      br_addr = 9'h1FF;
      cyc();
      cyc();
      chk("f1ff_addr", mem_addr, 9'h1FF);
      br_valid = 0;
      cyc();
      chk("wrap_pc", pc, 0);
      cyc();
      chk("wrap_addr", mem_addr, 0);
      cyc();
      cyc();
      chk("f1_addr", mem_addr, 1);
      br_valid = 1; br_addr = 9'h0AA;         // must be ignored by HALT
      cyc();
      chk("halt_opcode", opcode, 3'd7);
      cyc();
      chk("halt_flag", halted, 1);
      for (int i = 0; i < 100; i++) begin
         start = 1'($urandom_range(0, 1));
         instr_ready = 1'($urandom_range(0, 1));
         cyc();
         if (mem_re !== 1'b0 || halted !== 1'b1) chk("halt_hold", {mem_re, halted}, 2'b01);
      end
      chk("halt_final", halted, 1);
      chk("halt_pc", pc, 2);
      chk("halt_valid", instr_valid, 0);
      start = 0; instr_ready = 0; br_valid = 0;
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
